register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have port reg_a_write, input, 5 bits: writeback target register.
REQ-004 SHALL have port reg_we, input, 1 bit: writeback write enable.
REQ-005 SHALL have port reg_write, input, 32 bits: writeback data.
REQ-006 SHALL have ports reg_a_1 and reg_a_2, input, 5 bits each: decode read addresses.
REQ-007 SHALL have ports reg_rd_1 and reg_rd_2, output, 32 bits each: read data.
REQ-008 SHALL have ports reg_busy_1 and reg_busy_2, output, 1 bit each: operand has an in-flight write not yet available.
REQ-009 SHALL have port issue_valid, input, 1 bit: decode issues an instruction that will write issue_target.
REQ-010 SHALL have port issue_target, input, 5 bits: destination register of the issued instruction.
REQ-011 SHALL have port flush, input, 1 bit: pipeline flush that discards all in-flight writes.
REQ-012 SHALL have port issue_full, output, 1 bit: pending counter of issue_target is saturated.

Function
REQ-013 SHALL hold 31 writable 32-bit registers x1..x31; x0 SHALL read 0 and SHALL ignore writes.
REQ-014 SHALL update reg[reg_a_write] <= reg_write at the clock edge when reg_we=1 and reg_a_write!=0.
REQ-015 SHALL drive read ports combinationally (zero latency).
REQ-016 SHALL bypass same-cycle writes: when reg_we=1, reg_a_write=reg_a_n and reg_a_n!=0, reg_rd_n=reg_write.
REQ-017 SHALL keep one 2-bit pending counter per register x1..x31, counting issued-but-not-retired writes (maximum 3).
REQ-018 SHALL treat a retire as reg_we=1 with reg_a_write!=0.
REQ-019 SHALL update counter[t] at the clock edge as follows: issue only +1; retire only -1; issue and retire to the same register in one cycle, unchanged.
REQ-020 SHALL ignore an issue when issue_target=0.
REQ-021 SHALL ignore an issue while issue_full=1; the counter SHALL NOT wrap.
REQ-022 SHALL ignore a retire when counter=0 (counter stays 0), and the data write SHALL still occur.
REQ-023 SHALL assert issue_full combinationally when counter[issue_target]=3 and issue_target!=0.
REQ-024 SHALL assert reg_busy_n when counter[reg_a_n]>1, or when counter[reg_a_n]=1 and no same-cycle retire to reg_a_n occurs; reg_busy_n SHALL be 0 for x0.
REQ-025 SHALL clear all counters to 0 at the next edge when flush=1.
REQ-026 SHALL ignore any issue in a flush cycle.
REQ-027 SHALL still perform the data write of a retire in a flush cycle.
REQ-028 SHALL keep busy outputs during a flush cycle computed from pre-flush counters.

Reset
REQ-029 SHALL clear all registers to 0 and all counters to 0 immediately when rst_n=0, independent of clk.
REQ-030 SHALL drive reg_rd_n=0 (unless bypassing), reg_busy_n=0 and issue_full=0 while in reset.
REQ-031 SHALL ignore reg_we and issue_valid while rst_n=0.
REQ-032 SHALL perform the first update at the first rising edge after rst_n deasserts.

Structure
REQ-033 SHALL place REG_COUNT=32, the register-address width and the pending-counter width in package cpu_types.
REQ-034 SHALL implement the counter array, busy and full logic in sub-module reg_scoreboard, instantiated once.

Verification
REQ-035 SHALL cover write-then-read: write x5=0xDEADBEEF -> next cycle reg_rd_1(a=5)=0xDEADBEEF; write to x0 of 0x1234 -> reg_rd_1(a=0)=0.
REQ-036 SHALL cover bypass: same-cycle reg_we, x7=0xCAFEF00D with reg_a_2=7 -> reg_rd_2=0xCAFEF00D in that cycle.
REQ-037 SHALL cover scoreboard: issue x3 -> next cycle reg_busy_1(a=3)=1; retire x3 -> busy 0 in the retire cycle; two issues then one retire -> still busy.
REQ-038 SHALL cover saturation: three issues to x9 -> issue_full=1, fourth issue ignored; three retires -> counter 0, busy 0.
REQ-039 SHALL cover flush: issue x4 and x6, flush with retire x4=0x11 -> next cycle both not busy and x4 reads 0x11.
REQ-040 SHALL cover async reset: rst_n low mid-cycle after writes -> all reads 0 and busy 0 before the next edge.

Source files
------------

// File: rtl/cpu_types.sv
// cpu_types -- shared sizing and type definitions for the integer register file.
//
// Contents:
//   REG_COUNT     number of architectural registers (x0..x31)
//   REG_ADDR_W    width of a register address
//   PEND_W        width of a per-register pending-write counter
//   PEND_MAX      saturation value of a pending counter
//   reg_addr_t / reg_data_t / pend_t   matching typedefs
package cpu_types;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int PEND_W     = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
    typedef logic [PEND_W-1:0]     pend_t;

    localparam pend_t PEND_MAX = '1;

    // x0 is hard-wired, so it never takes part in writes or hazard tracking.
    function automatic logic is_live_reg(input reg_addr_t addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- per-register pending-write counters for x1..x31.
//
// Each counter tracks how many issued writes to that register have not yet
// retired (written back). Decode uses the busy flags to stall on operands
// with an outstanding producer, and issue_full to stall an issue that would
// overflow the counter of its destination.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   issue_valid         an instruction writing issue_target is issued
//   issue_target        destination register of that instruction
//   retire_valid        writeback enable (a retire when retire_target != 0)
//   retire_target       writeback destination register
//   flush               discard every in-flight write (all counters -> 0)
//   rd_addr_1/2         operand addresses being decoded
//   busy_1/2            operand still waiting on an in-flight write
//   issue_full          counter of issue_target is saturated
module reg_scoreboard
    import cpu_types::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      issue_valid,
    input  reg_addr_t issue_target,
    input  logic      retire_valid,
    input  reg_addr_t retire_target,
    input  logic      flush,
    input  reg_addr_t rd_addr_1,
    input  reg_addr_t rd_addr_2,
    output logic      busy_1,
    output logic      busy_2,
    output logic      issue_full
);

    // Entry 0 exists only so x0 can be indexed; it is never incremented.
    pend_t cnt_reg  [REG_COUNT];
    pend_t cnt_next [REG_COUNT];

    logic issue_take;
    logic retire_any;

    assign issue_full = is_live_reg(issue_target) && (cnt_reg[issue_target] == PEND_MAX);

    // An issue is dropped when it targets x0, would overflow, or collides with a flush.
    assign issue_take = issue_valid && is_live_reg(issue_target) && !issue_full && !flush;
    assign retire_any = retire_valid && is_live_reg(retire_target);

    always_comb begin
        cnt_next[0] = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            cnt_next[i] = cnt_reg[i];
            if (flush) begin
                cnt_next[i] = '0;
            end else begin
                // A retire against an empty counter is a stale writeback:
                // the data still lands, but the counter must not underflow.
                if (issue_take && (issue_target == reg_addr_t'(i))
                    && !(retire_any && (retire_target == reg_addr_t'(i)) && (cnt_reg[i] != '0))) begin
                    cnt_next[i] = cnt_reg[i] + pend_t'(1);
                end else if (!(issue_take && (issue_target == reg_addr_t'(i)))
                    && retire_any && (retire_target == reg_addr_t'(i)) && (cnt_reg[i] != '0)) begin
                    cnt_next[i] = cnt_reg[i] - pend_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    // Busy evaluation for both read ports. A single outstanding write that
    // retires this very cycle is forwarded by the register file bypass, so
    // the operand is already available.
    reg_addr_t  port_addr [2];
    logic [1:0] port_busy;

    assign port_addr[0] = rd_addr_1;
    assign port_addr[1] = rd_addr_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_busy
            pend_t port_cnt;
            logic  port_retiring;

            assign port_cnt      = cnt_reg[port_addr[gi]];
            assign port_retiring = retire_any && (retire_target == port_addr[gi]);
            assign port_busy[gi] = is_live_reg(port_addr[gi])
                                   && ((port_cnt > pend_t'(1))
                                       || ((port_cnt == pend_t'(1)) && !port_retiring));
        end
    endgenerate

    assign busy_1 = port_busy[0];
    assign busy_2 = port_busy[1];

endmodule

// File: rtl/register_file.sv
// register_file -- 32 x 32-bit integer register file with writeback bypass
// and a pending-write scoreboard.
//
// x0 always reads zero and discards writes. Reads are combinational and a
// same-cycle writeback to the addressed register is forwarded to the read
// port. Outstanding writes are tracked by reg_scoreboard.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reg_a_write, reg_we,  writeback address / enable / data
//   reg_write
//   reg_a_1, reg_a_2      decode read addresses
//   reg_rd_1, reg_rd_2    read data
//   reg_busy_1/2          operand has an in-flight write not yet available
//   issue_valid,          decode issues an instruction writing issue_target
//   issue_target
//   flush                 discard all in-flight writes
//   issue_full            pending counter of issue_target is saturated
module register_file
    import cpu_types::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] reg_a_write,
    input  logic                  reg_we,
    input  logic [REG_DATA_W-1:0] reg_write,
    input  logic [REG_ADDR_W-1:0] reg_a_1,
    input  logic [REG_ADDR_W-1:0] reg_a_2,
    output logic [REG_DATA_W-1:0] reg_rd_1,
    output logic [REG_DATA_W-1:0] reg_rd_2,
    output logic                  reg_busy_1,
    output logic                  reg_busy_2,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_target,
    input  logic                  flush,
    output logic                  issue_full
);

    // Flop array rather than block RAM: every entry must clear
    // asynchronously on reset and both read ports are zero-latency.
    reg_data_t regs [REG_COUNT];

    logic write_live;

    assign write_live = reg_we && is_live_reg(reg_a_write);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_live) begin
            regs[reg_a_write] <= reg_write;
        end
    end

    // Combinational read ports with writeback forwarding.
    reg_addr_t              rd_addr [2];
    logic [1:0][REG_DATA_W-1:0] rd_data;

    assign rd_addr[0] = reg_a_1;
    assign rd_addr[1] = reg_a_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = '0;
                if (is_live_reg(rd_addr[gi])) begin
                    if (write_live && (reg_a_write == rd_addr[gi])) begin
                        rd_data[gi] = reg_write;
                    end else begin
                        rd_data[gi] = regs[rd_addr[gi]];
                    end
                end
            end
        end
    endgenerate

    assign reg_rd_1 = rd_data[0];
    assign reg_rd_2 = rd_data[1];

    reg_scoreboard u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_target  (issue_target),
        .retire_valid  (reg_we),
        .retire_target (reg_a_write),
        .flush         (flush),
        .rd_addr_1     (reg_a_1),
        .rd_addr_2     (reg_a_2),
        .busy_1        (reg_busy_1),
        .busy_2        (reg_busy_2),
        .issue_full    (issue_full)
    );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file -- directed self-checking bench for register_file.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  reg_a_write;
    logic        reg_we;
    logic [31:0] reg_write;
    logic [4:0]  reg_a_1;
    logic [4:0]  reg_a_2;
    logic [31:0] reg_rd_1;
    logic [31:0] reg_rd_2;
    logic        reg_busy_1;
    logic        reg_busy_2;
    logic        issue_valid;
    logic [4:0]  issue_target;
    logic        flush;
    logic        issue_full;

    int passed;
    int total;

    register_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_a_write  (reg_a_write),
        .reg_we       (reg_we),
        .reg_write    (reg_write),
        .reg_a_1      (reg_a_1),
        .reg_a_2      (reg_a_2),
        .reg_rd_1     (reg_rd_1),
        .reg_rd_2     (reg_rd_2),
        .reg_busy_1   (reg_busy_1),
        .reg_busy_2   (reg_busy_2),
        .issue_valid  (issue_valid),
        .issue_target (issue_target),
        .flush        (flush),
        .issue_full   (issue_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        reg_we       = 1'b0;
        reg_a_write  = 5'd0;
        reg_write    = 32'h0;
        issue_valid  = 1'b0;
        issue_target = 5'd0;
        flush        = 1'b0;
    endtask

    // Advance past the next rising edge; inputs are changed only after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        reg_a_1 = 5'd5;
        reg_a_2 = 5'd9;
        issue_target = 5'd5;
        #2;
        total++;
        if (reg_rd_1 !== 32'h0 || reg_busy_1 !== 1'b0 || issue_full !== 1'b0)
            $display("FAIL reset_outputs: rd_1=%h busy_1=%b full=%b required 0/0/0", reg_rd_1, reg_busy_1, issue_full);
        else begin passed++; $display("check reset_outputs ok"); end
        // Writes and issues during reset must be ignored.
        reg_we = 1'b1; reg_a_write = 5'd9; reg_write = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_target = 5'd9;
        tick();
        idle();
        #1;
        total++;
        if (reg_rd_2 !== 32'h0 || reg_busy_2 !== 1'b0)
            $display("FAIL reset_ignore_we: rd_2=%h busy_2=%b required 0/0", reg_rd_2, reg_busy_2);
        else begin passed++; $display("check reset_ignore_we ok"); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        reg_we = 1'b1; reg_a_write = 5'd5; reg_write = 32'hDEAD_BEEF;
        tick();
        idle();
        reg_a_1 = 5'd5;
        #1;
        total++;
        if (reg_rd_1 !== 32'hDEAD_BEEF)
            $display("FAIL write_read_x5: got %h required %h", reg_rd_1, 32'hDEAD_BEEF);
        else begin passed++; $display("check write_read_x5 ok"); end
        reg_we = 1'b1; reg_a_write = 5'd0; reg_write = 32'h0000_1234;
        reg_a_1 = 5'd0;
        #1;
        total++;
        if (reg_rd_1 !== 32'h0)
            $display("FAIL x0_no_bypass: got %h required %h", reg_rd_1, 32'h0);
        else begin passed++; $display("check x0_no_bypass ok"); end
        tick();
        idle();
        #1;
        total++;
        if (reg_rd_1 !== 32'h0)
            $display("FAIL x0_reads_zero: got %h required %h", reg_rd_1, 32'h0);
        else begin passed++; $display("check x0_reads_zero ok"); end
    endtask

    task automatic test_bypass();
        reg_a_2 = 5'd7;
        reg_we = 1'b1; reg_a_write = 5'd7; reg_write = 32'hCAFE_F00D;
        #1;
        total++;
        if (reg_rd_2 !== 32'hCAFE_F00D)
            $display("FAIL bypass_x7: got %h required %h", reg_rd_2, 32'hCAFE_F00D);
        else begin passed++; $display("check bypass_x7 ok"); end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_target = 5'd3;
        tick();
        idle();
        reg_a_1 = 5'd3;
        #1;
        total++;
        if (reg_busy_1 !== 1'b1)
            $display("FAIL busy_after_issue: got %b required 1", reg_busy_1);
        else begin passed++; $display("check busy_after_issue ok"); end
        reg_we = 1'b1; reg_a_write = 5'd3; reg_write = 32'h0000_0033;
        #1;
        total++;
        if (reg_busy_1 !== 1'b0)
            $display("FAIL busy_retire_cycle: got %b required 0", reg_busy_1);
        else begin passed++; $display("check busy_retire_cycle ok"); end
        tick();
        idle();
        // Two issues then one retire: one write still outstanding.
        issue_valid = 1'b1; issue_target = 5'd3;
        tick();
        tick();
        idle();
        reg_we = 1'b1; reg_a_write = 5'd3; reg_write = 32'h0000_0034;
        #1;
        total++;
        if (reg_busy_1 !== 1'b1)
            $display("FAIL busy_two_pending_retiring: got %b required 1", reg_busy_1);
        else begin passed++; $display("check busy_two_pending_retiring ok"); end
        tick();
        idle();
        #1;
        total++;
        if (reg_busy_1 !== 1'b1)
            $display("FAIL busy_one_left: got %b required 1", reg_busy_1);
        else begin passed++; $display("check busy_one_left ok"); end
        reg_we = 1'b1; reg_a_write = 5'd3; reg_write = 32'h0000_0035;
        tick();
        idle();
        #1;
        total++;
        if (reg_busy_1 !== 1'b0 || reg_rd_1 !== 32'h0000_0035)
            $display("FAIL x3_drained: busy=%b rd=%h required 0/%h", reg_busy_1, reg_rd_1, 32'h0000_0035);
        else begin passed++; $display("check x3_drained ok"); end
    endtask

    task automatic test_saturation();
        reg_a_1 = 5'd9;
        issue_valid = 1'b1; issue_target = 5'd9;
        #1;
        total++;
        if (issue_full !== 1'b0)
            $display("FAIL full_initially_clear: got %b required 0", issue_full);
        else begin passed++; $display("check full_initially_clear ok"); end
        tick();
        tick();
        tick();
        total++;
        if (issue_full !== 1'b1)
            $display("FAIL full_after_three: got %b required 1", issue_full);
        else begin passed++; $display("check full_after_three ok"); end
        tick();          // fourth issue must be dropped, counter stays at 3
        idle();
        issue_target = 5'd9;
        #1;
        total++;
        if (issue_full !== 1'b1)
            $display("FAIL full_no_wrap: got %b required 1", issue_full);
        else begin passed++; $display("check full_no_wrap ok"); end
        // Retire twice: one outstanding write remains.
        reg_we = 1'b1; reg_a_write = 5'd9; reg_write = 32'h0000_0009;
        tick();
        tick();
        idle();
        issue_target = 5'd9;
        #1;
        total++;
        if (reg_busy_1 !== 1'b1 || issue_full !== 1'b0)
            $display("FAIL sat_one_left: busy=%b full=%b required 1/0", reg_busy_1, issue_full);
        else begin passed++; $display("check sat_one_left ok"); end
        reg_we = 1'b1; reg_a_write = 5'd9; reg_write = 32'h0000_0009;
        tick();
        // Extra retire on an empty counter: data still lands, no underflow.
        reg_write = 32'h0000_0099;
        tick();
        idle();
        #1;
        total++;
        if (reg_busy_1 !== 1'b0 || reg_rd_1 !== 32'h0000_0099)
            $display("FAIL sat_drained: busy=%b rd=%h required 0/%h", reg_busy_1, reg_rd_1, 32'h0000_0099);
        else begin passed++; $display("check sat_drained ok"); end
        issue_valid = 1'b1; issue_target = 5'd9;
        tick();
        idle();
        #1;
        total++;
        if (reg_busy_1 !== 1'b1)
            $display("FAIL no_underflow: busy=%b required 1", reg_busy_1);
        else begin passed++; $display("check no_underflow ok"); end
        reg_we = 1'b1; reg_a_write = 5'd9; reg_write = 32'h0000_0099;
        tick();
        idle();
    endtask

    task automatic test_flush();
        reg_a_1 = 5'd4;
        reg_a_2 = 5'd6;
        issue_valid = 1'b1; issue_target = 5'd4;
        tick();
        issue_target = 5'd6;
        tick();
        idle();
        #1;
        total++;
        if (reg_busy_1 !== 1'b1 || reg_busy_2 !== 1'b1)
            $display("FAIL pre_flush_busy: busy1=%b busy2=%b required 1/1", reg_busy_1, reg_busy_2);
        else begin passed++; $display("check pre_flush_busy ok"); end
        flush = 1'b1;
        reg_we = 1'b1; reg_a_write = 5'd4; reg_write = 32'h0000_0011;
        issue_valid = 1'b1; issue_target = 5'd6;
        #1;
        total++;
        if (reg_busy_1 !== 1'b0 || reg_busy_2 !== 1'b1)
            $display("FAIL flush_cycle_busy: busy1=%b busy2=%b required 0/1", reg_busy_1, reg_busy_2);
        else begin passed++; $display("check flush_cycle_busy ok"); end
        tick();
        idle();
        #1;
        total++;
        if (reg_busy_1 !== 1'b0 || reg_busy_2 !== 1'b0 || reg_rd_1 !== 32'h0000_0011)
            $display("FAIL post_flush: busy1=%b busy2=%b rd1=%h required 0/0/%h",
                     reg_busy_1, reg_busy_2, reg_rd_1, 32'h0000_0011);
        else begin passed++; $display("check post_flush ok"); end
    endtask

    task automatic test_async_reset();
        reg_a_1 = 5'd10;
        reg_a_2 = 5'd5;
        reg_we = 1'b1; reg_a_write = 5'd10; reg_write = 32'hA5A5_A5A5;
        issue_valid = 1'b1; issue_target = 5'd10;
        tick();
        idle();
        issue_target = 5'd10;
        #1;
        total++;
        if (reg_rd_1 !== 32'hA5A5_A5A5 || reg_busy_1 !== 1'b1 || reg_rd_2 !== 32'hDEAD_BEEF)
            $display("FAIL pre_reset_state: rd1=%h busy1=%b rd2=%h required %h/1/%h",
                     reg_rd_1, reg_busy_1, reg_rd_2, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
        else begin passed++; $display("check pre_reset_state ok"); end
        #1;
        rst_n = 1'b0;    // mid-cycle, well before the next rising edge
        #1;
        total++;
        if (reg_rd_1 !== 32'h0 || reg_rd_2 !== 32'h0 || reg_busy_1 !== 1'b0 || issue_full !== 1'b0)
            $display("FAIL async_reset: rd1=%h rd2=%h busy1=%b full=%b required 0/0/0/0",
                     reg_rd_1, reg_rd_2, reg_busy_1, issue_full);
        else begin passed++; $display("check async_reset ok"); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reg_a_1 = 5'd0;
        reg_a_2 = 5'd0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_saturation();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
